// File: rtl/game_flow_sequencer.sv
// Game-flow controller: sequences WELCOME -> SERVE -> PLAY -> (LOST -> SERVE)* -> GAME_OVER.
// Owns the life counter, start-key edge detect and the frame-counted screen timers.
module game_flow_sequencer #(
  parameter int INIT_LIFE    = 3,
  parameter int SERVE_FRAMES = 30,
  parameter int LOST_FRAMES  = 60,
  parameter int END_FRAMES   = 600,
  parameter int FRAME_CNT_W  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       startOfFrame,
  input  logic       key0IsPressed,
  input  logic       ballLost,
  output logic       start,
  output logic       game_end,
  output logic [3:0] life,
  output logic       round_reset,
  output logic       play_en,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    WELCOME   = 3'd0,
    SERVE     = 3'd1,
    PLAY      = 3'd2,
    LOST      = 3'd3,
    GAME_OVER = 3'd4
  } state_t;

  localparam logic [3:0]             LIFE_INIT  = 4'(INIT_LIFE);
  localparam logic [FRAME_CNT_W-1:0] SERVE_LAST = FRAME_CNT_W'(SERVE_FRAMES - 1);
  localparam logic [FRAME_CNT_W-1:0] LOST_LAST  = FRAME_CNT_W'(LOST_FRAMES - 1);
  localparam logic [FRAME_CNT_W-1:0] END_LAST   = FRAME_CNT_W'(END_FRAMES - 1);

  state_t                 state_q, state_d;
  logic [3:0]             life_q, life_d;
  logic [FRAME_CNT_W-1:0] timer_q, timer_d;
  logic                   key0Prev_q;
  logic                   roundReset_q, roundReset_d;
  logic                   keyRise;

  // key0Prev resets high so a key held through reset cannot start a game
  assign keyRise = key0IsPressed & ~key0Prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= WELCOME;
      life_q       <= LIFE_INIT;
      timer_q      <= '0;
      key0Prev_q   <= 1'b1;
      roundReset_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      life_q       <= life_d;
      timer_q      <= timer_d;
      key0Prev_q   <= key0IsPressed;
      roundReset_q <= roundReset_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    life_d       = life_q;
    timer_d      = timer_q;
    roundReset_d = 1'b0;
    unique case (state_q)
      WELCOME: begin
        if (keyRise) begin
          state_d      = SERVE;
          life_d       = LIFE_INIT;
          timer_d      = '0;
          roundReset_d = 1'b1;
        end
      end
      SERVE: begin
        if (startOfFrame) begin
          if (timer_q == SERVE_LAST) begin
            state_d = PLAY;
            timer_d = '0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
      end
      PLAY: begin
        // ballLost takes priority over any coincident frame pulse
        if (ballLost) begin
          timer_d = '0;
          if (life_q <= 4'd1) begin
            state_d = GAME_OVER;
            life_d  = 4'd0;
          end else begin
            state_d = LOST;
            life_d  = life_q - 4'd1;
          end
        end
      end
      LOST: begin
        if (startOfFrame) begin
          if (timer_q == LOST_LAST) begin
            state_d      = SERVE;
            timer_d      = '0;
            roundReset_d = 1'b1;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
      end
      GAME_OVER: begin
        life_d = 4'd0;
        if (keyRise || (startOfFrame && timer_q == END_LAST)) begin
          state_d = WELCOME;
          timer_d = '0;
        end else if (startOfFrame) begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: begin
        state_d = WELCOME;
        life_d  = LIFE_INIT;
        timer_d = '0;
      end
    endcase
  end

  assign start       = (state_q == SERVE) || (state_q == PLAY) || (state_q == LOST);
  assign game_end    = (state_q == GAME_OVER);
  assign play_en     = (state_q == PLAY);
  assign life        = life_q;
  assign round_reset = roundReset_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_game_flow_sequencer.sv
// Self-checking bench for game_flow_sequencer: scripted scenarios plus random stimulus,
// compared every cycle against a frames-remaining behavioural model.
module tb_game_flow_sequencer;

  localparam int INIT_LIFE    = 3;
  localparam int SERVE_FRAMES = 30;
  localparam int LOST_FRAMES  = 60;
  localparam int END_FRAMES   = 600;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       startOfFrame = 1'b0;
  logic       key0IsPressed = 1'b1;
  logic       ballLost = 1'b0;
  logic       start, game_end, round_reset, play_en;
  logic [3:0] life;
  logic [2:0] state_dbg;

  int vectors = 0;
  int miscompares = 0;

  // model: 0 welcome, 1 serve, 2 play, 3 lost, 4 game over
  int mState, mLife, mLeft;
  bit mKeyPrev, mRR, mRise;

  game_flow_sequencer #(
    .INIT_LIFE(INIT_LIFE), .SERVE_FRAMES(SERVE_FRAMES), .LOST_FRAMES(LOST_FRAMES),
    .END_FRAMES(END_FRAMES), .FRAME_CNT_W(10)
  ) dut (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .key0IsPressed(key0IsPressed),
    .ballLost(ballLost), .start(start), .game_end(game_end), .life(life),
    .round_reset(round_reset), .play_en(play_en), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mState = 0; mLife = INIT_LIFE; mLeft = 0; mKeyPrev = 1'b1; mRR = 1'b0;
    end else begin
      mRise = key0IsPressed && !mKeyPrev;
      mKeyPrev = key0IsPressed;
      mRR = 1'b0;
      case (mState)
        0: if (mRise) begin mState = 1; mLife = INIT_LIFE; mLeft = SERVE_FRAMES; mRR = 1'b1; end
        1: if (startOfFrame) begin
             mLeft = mLeft - 1;
             if (mLeft == 0) mState = 2;
           end
        2: if (ballLost) begin
             if (mLife <= 1) begin mLife = 0; mState = 4; mLeft = END_FRAMES; end
             else begin mLife = mLife - 1; mState = 3; mLeft = LOST_FRAMES; end
           end
        3: if (startOfFrame) begin
             mLeft = mLeft - 1;
             if (mLeft == 0) begin mState = 1; mLeft = SERVE_FRAMES; mRR = 1'b1; end
           end
        default: begin
             if (startOfFrame) mLeft = mLeft - 1;
             if (mRise || mLeft == 0) mState = 0;
           end
      endcase
    end
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    checkOutput("state_dbg", int'(state_dbg), mState);
    checkOutput("life", int'(life), mLife);
    checkOutput("start", int'(start), int'(mState >= 1 && mState <= 3));
    checkOutput("game_end", int'(game_end), int'(mState == 4));
    checkOutput("play_en", int'(play_en), int'(mState == 2));
    checkOutput("round_reset", int'(round_reset), int'(mRR));
  end

  // inputs change at posedge+1 and are sampled by the next posedge
  task automatic applyStimulus(input bit s, input bit k, input bit b);
    startOfFrame = s; key0IsPressed = k; ballLost = b;
    @(posedge clk); #1;
  endtask

  task automatic frames(input int n, input bit k);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b1, k, 1'b0);
      if (i != n - 1) repeat (3) applyStimulus(1'b0, k, 1'b0);
    end
  endtask

  task automatic pressKey();
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
  endtask

  task automatic drainToGameOver();
    for (int i = 0; i < INIT_LIFE - 1; i++) begin
      frames(SERVE_FRAMES, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b1);
      frames(LOST_FRAMES, 1'b0);
    end
    frames(SERVE_FRAMES, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_state", int'(state_dbg), 0);
    checkOutput("rst_life", int'(life), 3);
    reset = 1'b0;
    repeat (5) applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("held_key_state", int'(state_dbg), 0);
    checkOutput("held_key_start", int'(start), 0);

    pressKey();
    checkOutput("serve_entry", int'(state_dbg), 1);
    checkOutput("serve_rr", int'(round_reset), 1);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("serve_rr_width", int'(round_reset), 0);
    checkOutput("serve_ignore_lost", int'(life), 3);

    frames(SERVE_FRAMES - 1, 1'b0);
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("serve_29", int'(state_dbg), 1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("serve_30", int'(state_dbg), 2);
    checkOutput("play_en", int'(play_en), 1);

    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("lost_state", int'(state_dbg), 3);
    checkOutput("lost_life", int'(life), 2);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("lost_no_double", int'(life), 2);
    frames(LOST_FRAMES, 1'b0);
    checkOutput("lost_to_serve", int'(state_dbg), 1);
    checkOutput("lost_rr", int'(round_reset), 1);

    frames(SERVE_FRAMES, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("lost_wins_sof", int'(state_dbg), 3);
    frames(LOST_FRAMES - 1, 1'b0);
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("lost_59", int'(state_dbg), 3);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("lost_60", int'(state_dbg), 1);

    frames(SERVE_FRAMES, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("over_state", int'(state_dbg), 4);
    checkOutput("over_life", int'(life), 0);
    checkOutput("over_start", int'(start), 0);
    frames(END_FRAMES - 1, 1'b0);
    checkOutput("over_599", int'(game_end), 1);
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("over_timeout", int'(state_dbg), 0);

    pressKey();
    drainToGameOver();
    frames(10, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("over_key_exit", int'(state_dbg), 0);
    pressKey();
    checkOutput("restart_state", int'(state_dbg), 1);
    checkOutput("restart_life", int'(life), 3);

    applyStimulus(1'b0, 1'b0, 1'b0);
    drainToGameOver();
    frames(END_FRAMES - 1, 1'b0);
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("key_and_expiry", int'(state_dbg), 0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("key_and_expiry_once", int'(state_dbg), 0);

    pressKey();
    for (int i = 0; i < INIT_LIFE - 1; i++) begin
      frames(SERVE_FRAMES, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b1);
      frames(LOST_FRAMES, 1'b0);
    end
    frames(SERVE_FRAMES, 1'b0);
    checkOutput("pre_reset_life", int'(life), 1);
    #2 reset = 1'b1;
    #1;
    checkOutput("async_state", int'(state_dbg), 0);
    checkOutput("async_life", int'(life), 3);
    checkOutput("async_play_en", int'(play_en), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("post_reset_state", int'(state_dbg), 0);

    for (int i = 0; i < 6000; i++) begin
      bit s, k, b;
      s = ($urandom_range(0, 2) == 0);
      k = ($urandom_range(0, 3) == 0) ? ~key0IsPressed : key0IsPressed;
      b = ($urandom_range(0, 19) == 0);
      if (i == 3000) begin
        reset = 1'b1;
        applyStimulus(s, k, b);
        reset = 1'b0;
      end else begin
        applyStimulus(s, k, b);
      end
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
